// File: rtl/lieat_exu_com_wbck_pkg.sv
// ---------------------------------------------------------------------------
// lieat_exu_com_wbck_pkg
//
// Shared definitions for the common-ALU writeback path: datapath widths,
// the bit layout of one buffered writeback entry, and helpers that convert
// between the structured view and the flat word stored in the FIFO.
//
// Flat entry layout (LSB first):
//   [DATA_LSB  +: XLEN   ]  ALU result
//   [RDIDX_LSB +: REG_IDX]  destination register index
//   [RDWEN_BIT]             register write enable
//   [PC_LSB    +: XLEN   ]  instruction PC
//   [EBRK_BIT]              instruction is ebreak
// ---------------------------------------------------------------------------
package lieat_exu_com_wbck_pkg;

  localparam int XLEN    = 32;
  localparam int REG_IDX = 5;

  // Entry field offsets, shared with the infobus/writeback definitions.
  localparam int DATA_LSB  = 0;
  localparam int RDIDX_LSB = DATA_LSB + XLEN;
  localparam int RDWEN_BIT = RDIDX_LSB + REG_IDX;
  localparam int PC_LSB    = RDWEN_BIT + 1;
  localparam int EBRK_BIT  = PC_LSB + XLEN;
  localparam int ENTRY_W   = XLEN * 2 + REG_IDX + 2;

  typedef struct packed {
    logic               ebreak;
    logic [XLEN-1:0]    pc;
    logic               rdwen;
    logic [REG_IDX-1:0] rdidx;
    logic [XLEN-1:0]    data;
  } wbck_entry_t;

  // Pack an entry into the flat storage word using the shared offsets.
  function automatic logic [ENTRY_W-1:0] pack_entry(input wbck_entry_t e);
    logic [ENTRY_W-1:0] w;
    w                         = '0;
    w[DATA_LSB  +: XLEN]      = e.data;
    w[RDIDX_LSB +: REG_IDX]   = e.rdidx;
    w[RDWEN_BIT]              = e.rdwen;
    w[PC_LSB    +: XLEN]      = e.pc;
    w[EBRK_BIT]               = e.ebreak;
    return w;
  endfunction

  // Inverse of pack_entry.
  function automatic wbck_entry_t unpack_entry(input logic [ENTRY_W-1:0] w);
    wbck_entry_t e;
    e.data   = w[DATA_LSB  +: XLEN];
    e.rdidx  = w[RDIDX_LSB +: REG_IDX];
    e.rdwen  = w[RDWEN_BIT];
    e.pc     = w[PC_LSB    +: XLEN];
    e.ebreak = w[EBRK_BIT];
    return e;
  endfunction

endpackage

// File: rtl/lieat_gnrl_fifo2.sv
// ---------------------------------------------------------------------------
// lieat_gnrl_fifo2
//
// Generic two-deep valid/ready FIFO with synchronous flush. Both sides are
// driven purely from registered state: push_ready depends only on the
// occupancy count and pop_* come straight from the storage registers, so
// there is no combinational path from pop_ready to push_ready.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   flush        empty the FIFO on the next edge; same-cycle push/pop ignored
//   push_valid   producer offers push_data
//   push_ready   FIFO has room (count != 2)
//   push_data    WIDTH-bit word to store
//   pop_valid    head entry present (count != 0)
//   pop_ready    consumer takes the head entry
//   pop_data     head entry, read from the entry at the read pointer
// ---------------------------------------------------------------------------
module lieat_gnrl_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] mem [0:1];
  logic             rptr;
  logic             wptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rptr];

  // A flush cancels any handshake that happens in the same cycle.
  assign push = push_valid & push_ready & ~flush;
  assign pop  = pop_valid  & pop_ready  & ~flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload registers are reset as well, so the pop_data outputs
  // read all-zero straight out of reset instead of X; storage is only two
  // entries, so resetting it is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wptr] <= push_data;
    end
  end

endmodule

// File: rtl/lieat_exu_com_wbck.sv
// ---------------------------------------------------------------------------
// lieat_exu_com_wbck
//
// Two-entry elastic buffer between the common-ALU execute stage and the
// register-file writeback port. Results are delivered in order under a
// valid/ready handshake; one cycle of writeback back-pressure is absorbed
// without a bubble. Accepting an ebreak sets a sticky halt that blocks all
// further intake while already-buffered entries (including the ebreak
// itself, with its register write suppressed) drain to writeback.
//
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   exu_valid       ALU result offered
//   exu_ready       result accepted this cycle (room available and not halted)
//   exu_data        ALU result
//   exu_rdidx       destination register
//   exu_rdwen       result writes exu_rdidx
//   exu_pc          instruction PC
//   exu_ebreak      instruction is ebreak
//   exu_flush       drop all buffered, uncommitted entries on the next edge
//   wb_valid        head entry presented to writeback
//   wb_ready        writeback consumes the head entry
//   wb_data         head result
//   wb_rdidx        head destination register
//   wb_rdwen        head write enable (always 0 for the ebreak entry)
//   wb_pc           head PC
//   wb_ebreak       head is the ebreak instruction
//   halt            sticky; set once an ebreak has been accepted
// ---------------------------------------------------------------------------
module lieat_exu_com_wbck
  import lieat_exu_com_wbck_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exu_valid,
  output logic               exu_ready,
  input  logic [XLEN-1:0]    exu_data,
  input  logic [REG_IDX-1:0] exu_rdidx,
  input  logic               exu_rdwen,
  input  logic [XLEN-1:0]    exu_pc,
  input  logic               exu_ebreak,
  input  logic               exu_flush,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [XLEN-1:0]    wb_data,
  output logic [REG_IDX-1:0] wb_rdidx,
  output logic               wb_rdwen,
  output logic [XLEN-1:0]    wb_pc,
  output logic               wb_ebreak,
  output logic               halt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } run_state_e;

  run_state_e         state_q;
  run_state_e         state_d;
  logic               halted;
  logic               fifo_push_ready;
  logic               push_fire;
  wbck_entry_t        in_entry;
  wbck_entry_t        out_entry;
  logic [ENTRY_W-1:0] fifo_out;

  assign halted = (state_q == HALTED);

  // exu_ready is built from registered state only (count and halt).
  assign exu_ready = fifo_push_ready & ~halted;
  assign push_fire = exu_valid & exu_ready;

  // An ebreak must never write the register file, whatever rdwen says.
  assign in_entry = '{
    ebreak: exu_ebreak,
    pc:     exu_pc,
    rdwen:  exu_rdwen & ~exu_ebreak,
    rdidx:  exu_rdidx,
    data:   exu_data
  };

  lieat_gnrl_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (exu_flush),
    .push_valid (exu_valid & ~halted),
    .push_ready (fifo_push_ready),
    .push_data  (pack_entry(in_entry)),
    .pop_valid  (wb_valid),
    .pop_ready  (wb_ready),
    .pop_data   (fifo_out)
  );

  assign out_entry = unpack_entry(fifo_out);
  assign wb_data   = out_entry.data;
  assign wb_rdidx  = out_entry.rdidx;
  assign wb_rdwen  = out_entry.rdwen;
  assign wb_pc     = out_entry.pc;
  assign wb_ebreak = out_entry.ebreak;

  // Halt state machine: RUN -> HALTED on an accepted ebreak that is not
  // cancelled by a same-cycle flush. Only reset leaves HALTED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before any branch so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (push_fire && exu_ebreak && !exu_flush) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign halt = halted;

endmodule

// File: tb/tb_lieat_exu_com_wbck.sv
// ---------------------------------------------------------------------------
// tb_lieat_exu_com_wbck
//
// Self-checking bench. A queue-based model tracks what writeback must see;
// a negedge process compares every DUT output against it each cycle.
// Directed sequences add hand-computed literal expectations, and random
// phases exercise back-pressure, flushes, ebreaks and resets.
// ---------------------------------------------------------------------------
module tb_lieat_exu_com_wbck;
  import lieat_exu_com_wbck_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               exu_valid;
  logic               exu_ready;
  logic [XLEN-1:0]    exu_data;
  logic [REG_IDX-1:0] exu_rdidx;
  logic               exu_rdwen;
  logic [XLEN-1:0]    exu_pc;
  logic               exu_ebreak;
  logic               exu_flush;
  logic               wb_valid;
  logic               wb_ready;
  logic [XLEN-1:0]    wb_data;
  logic [REG_IDX-1:0] wb_rdidx;
  logic               wb_rdwen;
  logic [XLEN-1:0]    wb_pc;
  logic               wb_ebreak;
  logic               halt;

  always #5 clk = ~clk;

  lieat_exu_com_wbck dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exu_valid  (exu_valid),
    .exu_ready  (exu_ready),
    .exu_data   (exu_data),
    .exu_rdidx  (exu_rdidx),
    .exu_rdwen  (exu_rdwen),
    .exu_pc     (exu_pc),
    .exu_ebreak (exu_ebreak),
    .exu_flush  (exu_flush),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rdidx   (wb_rdidx),
    .wb_rdwen   (wb_rdwen),
    .wb_pc      (wb_pc),
    .wb_ebreak  (wb_ebreak),
    .halt       (halt)
  );

  typedef struct {
    logic [XLEN-1:0]    data;
    logic [REG_IDX-1:0] rdidx;
    logic               rdwen;
    logic [XLEN-1:0]    pc;
    logic               ebreak;
  } exp_t;

  exp_t q[$];
  bit   m_halt = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two results plus a halt flag.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_halt = 1'b0;
      end else begin
        bit   can_push;
        bit   do_push;
        bit   do_pop;
        exp_t e;
        can_push = (q.size() < 2) && !m_halt;
        do_push  = exu_valid && can_push;
        do_pop   = (q.size() > 0) && wb_ready;
        if (exu_flush) begin
          q.delete();
        end else begin
          if (do_pop) void'(q.pop_front());
          if (do_push) begin
            e.data   = exu_data;
            e.rdidx  = exu_rdidx;
            e.rdwen  = exu_rdwen && !exu_ebreak;
            e.pc     = exu_pc;
            e.ebreak = exu_ebreak;
            q.push_back(e);
            if (exu_ebreak) m_halt = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("exu_ready", exu_ready, (q.size() < 2) && !m_halt);
      check("wb_valid", wb_valid, q.size() > 0);
      check("halt", halt, m_halt);
      if (q.size() > 0) begin
        check("wb_data", wb_data, q[0].data);
        check("wb_rdidx", wb_rdidx, q[0].rdidx);
        check("wb_rdwen", wb_rdwen, q[0].rdwen);
        check("wb_pc", wb_pc, q[0].pc);
        check("wb_ebreak", wb_ebreak, q[0].ebreak);
      end
      if (!rst_n) begin
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_pc", wb_pc, 0);
        check("rst_wb_rdidx", wb_rdidx, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    exu_valid  = 1'b0;
    exu_data   = '0;
    exu_rdidx  = '0;
    exu_rdwen  = 1'b0;
    exu_pc     = '0;
    exu_ebreak = 1'b0;
    exu_flush  = 1'b0;
  endtask

  task automatic offer(input logic [XLEN-1:0] d, input logic [REG_IDX-1:0] rd,
                       input logic wen, input logic [XLEN-1:0] pc, input logic ebrk);
    exu_valid  = 1'b1;
    exu_data   = d;
    exu_rdidx  = rd;
    exu_rdwen  = wen;
    exu_pc     = pc;
    exu_ebreak = ebrk;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_halt"}, halt, 0);
    check({tag, "_exu_ready"}, exu_ready, 1);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_wb_rdidx"}, wb_rdidx, 0);
    check({tag, "_wb_rdwen"}, wb_rdwen, 0);
    check({tag, "_wb_pc"}, wb_pc, 0);
    check({tag, "_wb_ebreak"}, wb_ebreak, 0);
  endtask

  task automatic random_cycles(input int n, input bit allow_ebreak);
    for (int i = 0; i < n; i++) begin
      exu_valid  = ($urandom_range(0, 3) != 0);
      exu_data   = $urandom;
      exu_rdidx  = REG_IDX'($urandom_range(0, 31));
      exu_rdwen  = $urandom_range(0, 1) != 0;
      exu_pc     = $urandom;
      exu_ebreak = allow_ebreak && ($urandom_range(0, 23) == 0);
      exu_flush  = ($urandom_range(0, 15) == 0);
      wb_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_ready = 1'b0;
    idle();

    // Reset state.
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Single result: visible the cycle after the push, gone after the pop.
    wb_ready = 1'b1;
    offer(32'h0000_1234, 5'd5, 1'b1, 32'h8000_0000, 1'b0);
    tick();
    idle();
    check("single_valid", wb_valid, 1);
    check("single_data", wb_data, 32'h0000_1234);
    check("single_rdidx", wb_rdidx, 5);
    check("single_rdwen", wb_rdwen, 1);
    check("single_pc", wb_pc, 32'h8000_0000);
    tick();
    check("single_drained", wb_valid, 0);

    // Back-pressure: fill both entries, third offer refused, drain in order.
    wb_ready = 1'b0;
    offer(32'h11, 5'd1, 1'b1, 32'h100, 1'b0);
    tick();
    offer(32'h22, 5'd2, 1'b1, 32'h104, 1'b0);
    tick();
    offer(32'h33, 5'd3, 1'b1, 32'h108, 1'b0);
    check("bp_full_ready", exu_ready, 0);
    check("bp_head_a", wb_data, 32'h11);
    wb_ready = 1'b1;
    check("bp_full_ready_wb1", exu_ready, 0);
    tick();
    idle();
    check("bp_ready_after_pop", exu_ready, 1);
    check("bp_head_b", wb_data, 32'h22);
    tick();
    check("bp_drained", wb_valid, 0);

    // Streaming: one result per cycle, no bubbles.
    for (int i = 0; i < 8; i++) begin
      offer(XLEN'(i), REG_IDX'(i), 1'b1, 32'h200 + XLEN'(4 * i), 1'b0);
      check("stream_ready", exu_ready, 1);
      tick();
      check("stream_valid", wb_valid, 1);
      check("stream_data", wb_data, XLEN'(i));
    end
    idle();
    tick();
    check("stream_drained", wb_valid, 0);

    // Flush of a full buffer with a same-cycle offer and pop.
    wb_ready = 1'b0;
    offer(32'h44, 5'd4, 1'b1, 32'h300, 1'b0);
    tick();
    offer(32'h55, 5'd5, 1'b1, 32'h304, 1'b0);
    tick();
    offer(32'h66, 5'd6, 1'b1, 32'h308, 1'b0);
    exu_flush = 1'b1;
    wb_ready  = 1'b1;
    tick();
    idle();
    check("flush_valid", wb_valid, 0);
    check("flush_ready", exu_ready, 1);
    check("flush_halt", halt, 0);
    tick();
    check("flush_nothing_captured", wb_valid, 0);

    // Flush with a same-cycle ebreak push must not halt.
    wb_ready = 1'b0;
    offer(32'h77, 5'd7, 1'b1, 32'h400, 1'b0);
    tick();
    offer(32'h88, 5'd8, 1'b1, 32'h404, 1'b1);
    exu_flush = 1'b1;
    wb_ready  = 1'b1;
    tick();
    idle();
    check("flush_ebrk_valid", wb_valid, 0);
    check("flush_ebrk_halt", halt, 0);
    check("flush_ebrk_ready", exu_ready, 1);

    // Random traffic without ebreak.
    random_cycles(400, 1'b0);
    wb_ready = 1'b1;
    repeat (3) tick();

    // Ebreak: sticky halt, older entry and ebreak entry both drain.
    wb_ready = 1'b0;
    offer(32'hAA, 5'd3, 1'b1, 32'h8000_000C, 1'b0);
    tick();
    offer(32'hEB, 5'd7, 1'b1, 32'h8000_0010, 1'b1);
    tick();
    offer(32'hBB, 5'd9, 1'b1, 32'h8000_0014, 1'b0);
    check("ebrk_halt", halt, 1);
    check("ebrk_ready", exu_ready, 0);
    check("ebrk_x_data", wb_data, 32'hAA);
    check("ebrk_x_rdwen", wb_rdwen, 1);
    wb_ready = 1'b1;
    tick();
    check("ebrk_entry_valid", wb_valid, 1);
    check("ebrk_entry_flag", wb_ebreak, 1);
    check("ebrk_entry_rdwen", wb_rdwen, 0);
    check("ebrk_entry_pc", wb_pc, 32'h8000_0010);
    tick();
    check("ebrk_drained", wb_valid, 0);
    repeat (5) tick();
    check("ebrk_never_accepted", wb_valid, 0);
    check("ebrk_halt_sticky", halt, 1);
    check("ebrk_ready_stays_0", exu_ready, 0);
    idle();

    // Asynchronous reset with a full buffer and halt set.
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    wb_ready = 1'b0;
    offer(32'hC1, 5'd11, 1'b1, 32'h500, 1'b0);
    tick();
    offer(32'hC2, 5'd12, 1'b1, 32'h504, 1'b1);
    tick();
    idle();
    check("pre_rst_halt", halt, 1);
    check("pre_rst_valid", wb_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;

    // Random traffic with ebreaks; reset between rounds to clear halt.
    for (int r = 0; r < 3; r++) begin
      random_cycles(250, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
